// File: rtl/dd_scan_driver.sv
// dd_scan_driver: time-multiplexed 7-segment display driver.
// Scans DIGITS digits one at a time with a one-hot gate strobe and a matching
// segment pattern. Every digit is preceded by a dark blanking interval that
// suppresses ghosting. Inputs are snapshotted only at frame start, so a frame
// is never torn by input changes part way through it.
module dd_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int ON_CYCLES    = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clkBase,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   digitData,
  input  logic [DIGITS-1:0]     dpMask,
  input  logic [DIGITS-1:0]     blankMask,
  output logic [DIGITS-1:0]     gate,
  output logic [7:0]            led,
  output logic                  frameStart
);

  // The phase counter must hold the longer of the two phases, and at least 2.
  localparam int MAX_PHASE = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int MAX_CNT   = (MAX_PHASE < 2) ? 2 : MAX_PHASE;
  localparam int CW        = $clog2(MAX_CNT);
  localparam int IW        = (DIGITS < 2) ? 1 : $clog2(DIGITS);

  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_t;

  // Hex nibble to active-high {g,f,e,d,c,b,a} segment pattern.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   snap_data_q, snap_data_d;
  logic [DIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic [DIGITS-1:0]     snap_blank_q, snap_blank_d;
  logic [DIGITS-1:0]     gate_q, gate_d;
  logic [7:0]            led_q, led_d;
  logic                  fs_q, fs_d;
  logic                  start_s;
  logic [3:0]            nib_s;

  // Next-state logic for the scan FSM plus registered-output precomputation.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    snap_data_d  = snap_data_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    fs_d         = 1'b0;
    start_s      = 1'b0;
    gate_d       = '0;
    led_d        = 8'h00;
    nib_s        = 4'h0;

    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          start_s = 1'b1;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_ON: begin
          if (cnt_q == ON_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              start_s = 1'b1;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Frame start: wrap to digit 0 and take a fresh snapshot of the inputs.
    if (start_s) begin
      idx_d        = '0;
      cnt_d        = '0;
      snap_data_d  = digitData;
      snap_dp_d    = dpMask;
      snap_blank_d = blankMask;
      fs_d         = 1'b1;
      state_d      = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;
    end else begin
      fs_d = 1'b0;
    end

    // Outputs follow the next state so they can be registered without lag.
    if (state_d == ST_ON) begin
      nib_s  = snap_data_d[{idx_d, 2'b00} +: 4];
      gate_d = DIGITS'(1) << idx_d;
      if (snap_blank_d[idx_d]) begin
        led_d = 8'h00;
      end else begin
        led_d = {snap_dp_d[idx_d], seg_decode(nib_s)};
      end
    end else begin
      gate_d = '0;
      led_d  = 8'h00;
    end
  end

  // State, snapshot and output registers with synchronous active-low reset.
  always_ff @(posedge clkBase) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      snap_data_q  <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      gate_q       <= '0;
      led_q        <= 8'h00;
      fs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_data_q  <= snap_data_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      gate_q       <= gate_d;
      led_q        <= led_d;
      fs_q         <= fs_d;
    end
  end

  assign gate       = gate_q;
  assign led        = led_q;
  assign frameStart = fs_q;

endmodule
